// File: rtl/sc_lane_sched_pkg.sv
// Shared types and helpers for the lane scheduler.
// Optional build macro used by this block: SC_LANE_SCHED_STAGGER_EN.
package sc_lane_sched_pkg;

    localparam int LEVEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    // Shift period of one lane: base*(lane+1) saturated to cnt_w bits,
    // scaled down by the level, never below one clock.
    function automatic logic [63:0] sc_period(input int unsigned base,
                                              input int unsigned lane,
                                              input logic [LEVEL_W-1:0] lvl,
                                              input int unsigned cnt_w);
        logic [63:0] prod;
        logic [63:0] lim;
        logic [63:0] p;
        prod = 64'(base) * 64'(lane + 1);
        lim  = (64'd1 << cnt_w) - 64'd1;
        if (prod > lim) prod = lim;
        p = prod >> lvl;
        if (p == 64'd0) p = 64'd1;
        return p;
    endfunction

endpackage

// File: rtl/sc_lane_sched_tick.sv
// One lane timer: counts down, strobes vel for one cycle on wrap.
// With SC_LANE_SCHED_STAGGER_EN defined the initial load is offset by the
// lane index so lanes do not fire their first shift together.
import sc_lane_sched_pkg::*;

module sc_lane_tick #(
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned LANE_IDX = 0
) (
    input  logic             SC_REGDD_CLOCK,
    input  logic             SC_REGDD_RESET,
    input  logic             clr,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    output logic             vel
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_val;

`ifdef SC_LANE_SCHED_STAGGER_EN
    // period >= 1, so the modulo is always below period and cannot underflow
    assign load_val = (period - ONE) - (CNT_W'(LANE_IDX) % period);
`else
    assign load_val = period - ONE;
`endif

    // Countdown with zero-detect; period is sampled only at load and wrap
    always_ff @(posedge SC_REGDD_CLOCK or posedge SC_REGDD_RESET) begin
        if (SC_REGDD_RESET) begin
            cnt <= '0;
            vel <= 1'b0;
        end else begin
            vel <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (load) begin
                cnt <= load_val;
            end else if (run) begin
                if (cnt == '0) begin
                    cnt <= period - ONE;
                    vel <= 1'b1;
                end else begin
                    cnt <= cnt - ONE;
                end
            end
        end
    end

endmodule

// File: rtl/sc_lane_sched.sv
// Lane shift scheduler: one parallel-load cycle, then per-lane shift
// strobes at level-dependent rates, with pause/resume, reload and stop.
// Optional build macro: SC_LANE_SCHED_STAGGER_EN (staggered first shifts).
import sc_lane_sched_pkg::*;

module sc_lane_sched #(
    parameter int          LANES       = 4,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned PERIOD_BASE = 12500000
) (
    input  logic               SC_REGDD_CLOCK,
    input  logic               SC_REGDD_RESET,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               reload,
    input  logic [LEVEL_W-1:0] level,
    output logic [LANES-1:0]   load_shift,
    output logic [LANES-1:0]   vel,
    output logic               busy
);

    state_t state;
    logic   tick;
    logic   load;
    logic   clr;

    // Lane control: stop wins, reload and pause freeze the counters for the
    // cycle they are seen, and a PAUSE cycle with pause low already counts so
    // a lane parked at zero fires on the first RUN cycle after resume.
    always_comb begin
        clr  = stop;
        load = (state == LOAD) && !stop;
        tick = 1'b0;
        if (!stop) begin
            if (state == RUN)
                tick = !reload && !pause;
            else if (state == PAUSE)
                tick = !pause;
        end
    end

    // Sequencer with registered load_shift and busy
    always_ff @(posedge SC_REGDD_CLOCK or posedge SC_REGDD_RESET) begin
        if (SC_REGDD_RESET) begin
            state      <= IDLE;
            load_shift <= '0;
            busy       <= 1'b0;
        end else begin
            load_shift <= '0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= LOAD;
                            load_shift <= '1;
                            busy       <= 1'b1;
                        end
                    end
                    LOAD: state <= RUN;
                    RUN: begin
                        if (reload) begin
                            state      <= LOAD;
                            load_shift <= '1;
                        end else if (pause) begin
                            state <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (!pause) state <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [CNT_W-1:0] period;
        assign period = CNT_W'(sc_period(PERIOD_BASE, i, level, CNT_W));

        sc_lane_tick #(
            .CNT_W    (CNT_W),
            .LANE_IDX (i)
        ) u_tick (
            .SC_REGDD_CLOCK (SC_REGDD_CLOCK),
            .SC_REGDD_RESET (SC_REGDD_RESET),
            .clr            (clr),
            .load           (load),
            .run            (tick),
            .period         (period),
            .vel            (vel[i])
        );
    end

endmodule

// File: tb/tb_sc_lane_sched.sv
// Bench for sc_lane_sched: table of per-cycle vectors with expectations
// built from the period/latency formulas, plus a saturation sequence on a
// narrow-counter instance. Honours SC_LANE_SCHED_STAGGER_EN.
module tb_sc_lane_sched;

    localparam int PB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, reload = 1'b0;
    logic [1:0] level = 2'd0;
    logic [3:0] ls, vel;
    logic       busy;

    logic       s_start = 1'b0;
    logic [3:0] ls2, vel2;
    logic       busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_lane_sched #(.LANES(4), .CNT_W(24), .PERIOD_BASE(PB)) dut (
        .SC_REGDD_CLOCK (clk),
        .SC_REGDD_RESET (rst),
        .start          (start),
        .stop           (stop),
        .pause          (pause),
        .reload         (reload),
        .level          (level),
        .load_shift     (ls),
        .vel            (vel),
        .busy           (busy)
    );

    // Narrow counters: products 6,12,18,24 saturate to 15 for lanes 2 and 3
    sc_lane_sched #(.LANES(4), .CNT_W(4), .PERIOD_BASE(6)) dut_sat (
        .SC_REGDD_CLOCK (clk),
        .SC_REGDD_RESET (rst),
        .start          (s_start),
        .stop           (1'b0),
        .pause          (1'b0),
        .reload         (1'b0),
        .level          (2'd0),
        .load_shift     (ls2),
        .vel            (vel2),
        .busy           (busy2)
    );

    typedef struct {
        logic       rst, start, stop, pause, reload;
        logic [1:0] level;
        logic [3:0] ls, vel, msk;
        logic       busy;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] ls, vel, msk;
        logic       busy;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];

    function automatic int per(int i, int lvl);
        int p;
        p = (PB * (i + 1)) >> lvl;
        if (p < 1) p = 1;
        return p;
    endfunction

    function automatic int first(int i, int lvl);
        int p;
        p = per(i, lvl);
`ifdef SC_LANE_SCHED_STAGGER_EN
        return p + 2 - (i % p);
`else
        return p + 2;
`endif
    endfunction

    // vel expected in cycle c after a start at cycle 0, no interruptions
    function automatic logic [3:0] velv(int lvl, int c);
        logic [3:0] v;
        int f, p;
        v = 4'h0;
        for (int i = 0; i < 4; i++) begin
            f = first(i, lvl);
            p = per(i, lvl);
            if (c >= f && ((c - f) % p) == 0) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic add(input logic r, st, sp, pa, rl, input logic [1:0] lv,
                       input logic [3:0] e_ls, e_vel, msk, input logic e_busy);
        vec_t v;
        v.rst = r; v.start = st; v.stop = sp; v.pause = pa; v.reload = rl;
        v.level = lv; v.ls = e_ls; v.vel = e_vel; v.msk = msk; v.busy = e_busy;
        tv.push_back(v);
    endtask

    task automatic idle_vec();
        add(0, 0, 0, 0, 0, 2'd0, 4'h0, 4'h0, 4'hF, 1'b0);
    endtask

    task automatic chk(input string nm, input int k, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, k, got, exp);
        end
    endtask

    task automatic build();
        // Basic run at level 0, stray start in RUN at cycle 8, stop at 21
        for (int c = 0; c <= 21; c++)
            add(0, (c == 0 || c == 8), (c == 21), 0, 0, 2'd0,
                (c == 1) ? 4'hF : 4'h0, velv(0, c), 4'hF, (c >= 1));
        idle_vec();
        // Level 2: P = 1,2,3,4
        for (int c = 0; c <= 14; c++)
            add(0, (c == 0), (c == 14), 0, 0, 2'd2,
                (c == 1) ? 4'hF : 4'h0, velv(2, c), 4'hF, (c >= 1));
        idle_vec();
        // Pause high cycles 5..9: every event from cycle 6 on slips by 5
        for (int c = 0; c <= 24; c++)
            add(0, (c == 0), (c == 24), (c >= 5 && c <= 9), 0, 2'd0,
                (c == 1) ? 4'hF : 4'h0,
                (c < 6) ? velv(0, c) : (c >= 11 ? velv(0, c - 5) : 4'h0),
                4'hF, (c >= 1));
        idle_vec();
        // Level 0->1 at cycle 7: lane 0 keeps P=4 until its wrap at 9
        for (int c = 0; c <= 17; c++)
            add(0, (c == 0), (c == 17), 0, 0, (c >= 7) ? 2'd1 : 2'd0,
                (c == 1) ? 4'hF : 4'h0,
                {3'b000, (c == 6 || c == 10 || c == 12 || c == 14 || c == 16)},
                4'h1, (c >= 1));
        idle_vec();
        // stop and reload together in RUN -> IDLE, no load_shift
        for (int c = 0; c <= 6; c++)
            add(0, (c == 0), (c == 4), 0, (c == 4), 2'd0,
                (c == 1) ? 4'hF : 4'h0, (c <= 4) ? velv(0, c) : 4'h0,
                4'hF, (c >= 1 && c <= 4));
        // start and stop together in IDLE -> stays IDLE
        add(0, 1, 1, 0, 0, 2'd0, 4'h0, 4'h0, 4'hF, 1'b0);
        idle_vec();
        idle_vec();
        // reload in RUN at cycle 4 restarts the sequence
        for (int c = 0; c <= 16; c++)
            add(0, (c == 0), (c == 16), 0, (c == 4), 2'd0,
                (c == 1 || c == 5) ? 4'hF : 4'h0,
                (c >= 5) ? velv(0, c - 4) : velv(0, c), 4'hF, (c >= 1));
        idle_vec();
        // reset mid-RUN, then 50 quiet cycles with no start
        for (int c = 0; c <= 6; c++)
            add((c == 6), (c == 0), 0, 0, 0, 2'd0,
                (c == 1) ? 4'hF : 4'h0, (c < 6) ? velv(0, c) : 4'h0,
                4'hF, (c >= 1 && c < 6));
        for (int c = 0; c < 50; c++) idle_vec();
    endtask

    initial begin
        int   fst[4];
        int   efst[4];
        exp_t e;

        build();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ls", -1, ls, 4'h0);
        chk("reset_vel", -1, vel, 4'h0);
        chk("reset_busy", -1, {3'b000, busy}, 4'h0);

        for (int k = 0; k < tv.size(); k++) begin
            @(posedge clk);
            #1;
            rst    = tv[k].rst;
            start  = tv[k].start;
            stop   = tv[k].stop;
            pause  = tv[k].pause;
            reload = tv[k].reload;
            level  = tv[k].level;
            e.idx = k; e.ls = tv[k].ls; e.vel = tv[k].vel; e.msk = tv[k].msk; e.busy = tv[k].busy;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            chk("load_shift", e.idx, ls, e.ls);
            chk("vel", e.idx, vel & e.msk, e.vel & e.msk);
            chk("busy", e.idx, {3'b000, busy}, {3'b000, e.busy});
        end

        // Saturated periods: P = 6,12,15,15 on the narrow instance
`ifdef SC_LANE_SCHED_STAGGER_EN
        efst = '{8, 13, 15, 14};
`else
        efst = '{8, 14, 17, 17};
`endif
        fst = '{-1, -1, -1, -1};
        @(posedge clk);
        #1;
        s_start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            s_start = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (vel2[i] && fst[i] < 0) fst[i] = c;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fst[i] != efst[i]) begin
                errors++;
                $display("FAIL sat_first_vel lane %0d: got cycle %0d expected cycle %0d",
                         i, fst[i], efst[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_lane_sched.md
Name: sc_lane_sched

Overview:
- Scheduler for the vehicle-lane shift registers in the game level.
- Drives the per-lane LOAD_SHIFT and VEL strobes to N SC_REGDD-style 8-bit lane registers.
- Sequence: one parallel-load cycle first, then lane-specific shift rates chosen by game level, with pause/resume and stop.
- Sits between the game FSM (start/stop/pause/level) and the lane register bank.

Parameters:
- LANES, 4, number of lane registers controlled.
- CNT_W, 24, width of each lane tick counter.
- PERIOD_BASE, 12500000, lane-0 shift period in clocks at level 0 (0.25 s at 50 MHz).

Ports:
- SC_REGDD_CLOCK  in  1  system clock, rising edge.
- SC_REGDD_RESET  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begin load and run sequence.
- stop  in  1  pulse; return to IDLE from any state.
- pause  in  1  level; freeze all lane timing while high.
- reload  in  1  pulse; in RUN, re-load lanes and restart timing.
- level  in  2  game level, 0..3; higher is faster.
- load_shift  out  LANES  per-lane LOAD_SHIFT strobe.
- vel  out  LANES  per-lane VEL (shift enable) strobe.
- busy  out  1  high in LOAD, RUN and PAUSE.

Behaviour:
- All outputs are registered.
- Reset values: load_shift=0, vel=0, busy=0, state=IDLE, all counters=0. Reset mid-operation aborts immediately to these values.
- States: IDLE, LOAD, RUN, PAUSE.
- IDLE: outputs 0. start -> LOAD.
- LOAD: lasts exactly 1 cycle.
  - load_shift = all ones, vel = 0.
  - Each counter i loaded with P(i)-1.
  - Next state is RUN.
- RUN:
  - Each counter decrements by 1 per cycle.
  - When counter i == 0: vel[i]=1 in the following cycle (exactly 1 cycle wide), and counter reloads P(i)-1.
  - pause=1 -> PAUSE. reload -> LOAD.
- PAUSE:
  - Counters hold, vel=0, load_shift=0.
  - A lane at 0 when pause is sampled fires on the first RUN cycle after resume. No strobe is lost or duplicated.
  - pause=0 -> RUN.
- Period: P(i) = max(1, (PERIOD_BASE*(i+1)) >> level), computed at CNT_W bits. The product saturates to 2^CNT_W-1 on overflow.
- level is sampled only at counter reload and in LOAD. A change mid-period takes effect at that lane's next reload.
- Latency: start seen at cycle 0 -> load_shift at cycle 1 -> first vel[i] at cycle P(i)+2, then every P(i) cycles.
- Priority, highest first: stop > reload > pause > start. start outside IDLE is ignored. reload outside RUN is ignored.
- stop in any state: next cycle IDLE, all strobes 0, counters cleared.
- load_shift and vel are never high for the same lane in the same cycle.
- P(i)=1: vel[i] is high continuously in RUN, beginning at cycle 3.

Optional Feature:
- Macro: SC_LANE_SCHED_STAGGER_EN.
- Defined: in LOAD, counter i is loaded with (P(i)-1) - (i mod P(i)). Lanes never share their first shift cycle, spreading display updates. First vel[i] at cycle P(i)+2-(i mod P(i)). Steady-state period is unchanged.
- Undefined: all counters load P(i)-1, as above.

Decomposition:
- Package sc_lane_sched_pkg holds:
  - state encoding: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, PAUSE=2'd3;
  - LEVEL_W=2;
  - the saturating period function P(i, level).
- One natural sub-module, sc_lane_tick, instantiated LANES times via generate:
  - contains one counter, its reload and zero-detect;
  - inputs: load, run, period;
  - output: registered vel bit.
- sc_lane_sched keeps the FSM, priority logic and load_shift/busy registers.

Test Plan:
- Reset and idle: assert reset mid-RUN -> next edge load_shift=0, vel=0, busy=0; no strobes for 50 cycles with no start.
- Basic run (PERIOD_BASE=4, level=0, start at cycle 0):
  - load_shift=4'hF at cycle 1 only;
  - vel[0] at cycles 6,10,14;
  - vel[1] at cycles 10,18;
  - vel[3] at cycle 18.
- Level scaling (PERIOD_BASE=4): level=2 -> P=1,2,3,4. vel[0] high every RUN cycle from cycle 3; vel[2] every 3 cycles from cycle 5. Change level 0->1 mid-period -> new period only after the next strobe.
- Pause (PERIOD_BASE=4, level=0): pause high cycles 5-9 -> vel[0] absent at 6, appears at 11, then 15; busy stays 1.
- Priority: stop and reload in the same RUN cycle -> IDLE, no load_shift. start and stop together in IDLE -> stays IDLE. reload in RUN -> load_shift=all ones next cycle, counters restart.
- With SC_LANE_SCHED_STAGGER_EN (PERIOD_BASE=4, level=0): first vel at cycles 6,9,12,15 for lanes 0..3.
